phase_dwell_timer: RTL and testbench

Upstream control stage for the 2-bit traffic phase counter (inputs clr/r/up/dn, output count).
- Reads the counter's current phase back and times the dwell for that phase.
- Issues a one-cycle up pulse when the dwell expires.
- Drives r continuously during an emergency override, which forces phase 2'b10.
- Issues a one-cycle dn pulse on a manual step-back request.

---
 rtl/phase_dwell_timer.sv | 153 +++++++++++++++
 tb/tb_phase_dwell_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_dwell_timer.sv
// Dwell timer driving the up/dn/r controls of a 2-bit traffic phase counter.
// It times each phase read back on phase_in and also handles emergency override and manual step-back.
module phase_dwell_timer #(
    parameter int CW           = 8,
    parameter int TICK_DIV     = 1,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int RED_TICKS    = 20,
    parameter int ALLRED_TICKS = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [1:0]    phase_in,
    input  logic          emerg_req,
    input  logic          back_req,
    output logic          up,
    output logic          dn,
    output logic          r,
    output logic [CW-1:0] remain,
    output logic          busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // A dwell that truncates to zero would never expire cleanly, so it becomes one tick.
    function automatic logic [CW-1:0] clamp_dwell(input int ticks);
        logic [CW-1:0] t;
        t = CW'(ticks);
        return (t == CW'(0)) ? CW'(1) : t;
    endfunction

    localparam logic [CW-1:0] GREEN_D  = clamp_dwell(GREEN_TICKS);
    localparam logic [CW-1:0] YELLOW_D = clamp_dwell(YELLOW_TICKS);
    localparam logic [CW-1:0] RED_D    = clamp_dwell(RED_TICKS);
    localparam logic [CW-1:0] ALLRED_D = clamp_dwell(ALLRED_TICKS);

    function automatic logic [CW-1:0] dwell_sel(input logic [1:0] ph);
        logic [CW-1:0] d;
        case (ph)
            2'b00:   d = GREEN_D;
            2'b01:   d = YELLOW_D;
            2'b10:   d = RED_D;
            2'b11:   d = ALLRED_D;
            default: d = GREEN_D;
        endcase
        return d;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        BACK  = 3'd4,
        EMERG = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] remain_r, remain_s;
    logic [PW-1:0] presc_r, presc_s;
    logic          tick_s;
    logic          up_r, dn_r, r_r, busy_r;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state, dwell countdown and prescaler update.
    always_comb begin
        state_s  = state_r;
        remain_s = remain_r;
        presc_s  = presc_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                remain_s = dwell_sel(phase_in);
                presc_s  = PW'(0);
                state_s  = RUN;
            end
            RUN: begin
                presc_s = tick_s ? PW'(0) : presc_r + PW'(1);
                if (emerg_req) begin
                    state_s = EMERG;
                end else if (!en) begin
                    remain_s = CW'(0);
                    state_s  = IDLE;
                end else if (back_req) begin
                    state_s = BACK;
                end else if (tick_s && (remain_r > CW'(1))) begin
                    remain_s = remain_r - CW'(1);
                end else if (tick_s) begin
                    // Also catches a zero remain, so the count can never wrap below zero.
                    remain_s = CW'(0);
                    state_s  = STEP;
                end else begin
                    remain_s = remain_r;
                end
            end
            STEP: begin
                state_s = LOAD;
            end
            BACK: begin
                state_s = LOAD;
            end
            EMERG: begin
                if (emerg_req) begin
                    state_s = EMERG;
                end else begin
                    state_s = LOAD;
                end
            end
            default: begin
                state_s  = IDLE;
                remain_s = CW'(0);
                presc_s  = PW'(0);
            end
        endcase
    end

    // State register; outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= IDLE;
            remain_r <= CW'(0);
            presc_r  <= PW'(0);
            up_r     <= 1'b0;
            dn_r     <= 1'b0;
            r_r      <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            remain_r <= remain_s;
            presc_r  <= presc_s;
            up_r     <= (state_s == STEP);
            dn_r     <= (state_s == BACK);
            r_r      <= (state_s == EMERG);
            busy_r   <= (state_s != IDLE);
        end
    end

    assign up     = up_r;
    assign dn     = dn_r;
    assign r      = r_r;
    assign remain = remain_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_phase_dwell_timer.sv
// Directed bench: two timers, each closed in a loop with a behavioural 2-bit phase counter.
// The second timer has a divided tick.
module tb_phase_dwell_timer;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic       emerg_req = 1'b0;
    logic       back_req = 1'b0;
    logic [1:0] count1, count2;
    logic       up1, dn1, r1, busy1;
    logic       up2, dn2, r2, busy2;
    logic [7:0] remain1, remain2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    phase_dwell_timer #(.CW(8), .TICK_DIV(1), .GREEN_TICKS(4), .YELLOW_TICKS(2),
                        .RED_TICKS(3), .ALLRED_TICKS(1)) dut1 (
        .clk(clk), .clr(clr), .en(en), .phase_in(count1), .emerg_req(emerg_req),
        .back_req(back_req), .up(up1), .dn(dn1), .r(r1), .remain(remain1), .busy(busy1));

    phase_dwell_timer #(.CW(8), .TICK_DIV(3), .GREEN_TICKS(2), .YELLOW_TICKS(2),
                        .RED_TICKS(3), .ALLRED_TICKS(1)) dut2 (
        .clk(clk), .clr(clr), .en(en), .phase_in(count2), .emerg_req(emerg_req),
        .back_req(back_req), .up(up2), .dn(dn2), .r(r2), .remain(remain2), .busy(busy2));

    // Phase counter model: clr, then force-to-10, then up, then down with the 00 -> 10 skip.
    always @(posedge clk) begin
        if (clr) begin
            count1 <= 2'b00;
            count2 <= 2'b00;
        end else begin
            if (r1) count1 <= 2'b10;
            else if (up1) count1 <= count1 + 2'd1;
            else if (dn1) count1 <= (count1 == 2'b00) ? 2'b10 : count1 - 2'd1;
            if (r2) count2 <= 2'b10;
            else if (up2) count2 <= count2 + 2'd1;
            else if (dn2) count2 <= (count2 == 2'b00) ? 2'b10 : count2 - 2'd1;
        end
    end

    // Control pulses must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!clr) begin
            checks++;
            if ($countones({up1, dn1, r1}) > 1) begin
                errors++;
                $display("FAIL onehot: up/dn/r=%b required at most one high", {up1, dn1, r1});
            end
        end
    end

    task automatic restart();
        clr = 1'b1; en = 1'b0; emerg_req = 1'b0; back_req = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({up1, dn1, r1} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {up1, dn1, r1}); end
        checks++; if (remain1 !== 8'd0) begin errors++; $display("FAIL reset_remain: got %0d expected 0", remain1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (count1 !== 2'b00) begin errors++; $display("FAIL reset_count: got %b expected 00", count1); end
    endtask

    task automatic test_free_run();
        logic [1:0] exp_cnt [19] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                     2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        logic       exp_up  [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        restart();
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            checks++; if (count1 !== exp_cnt[i-1]) begin errors++; $display("FAIL free_count c%0d: got %b expected %b", i, count1, exp_cnt[i-1]); end
            checks++; if (up1 !== exp_up[i-1]) begin errors++; $display("FAIL free_up c%0d: got %b expected %b", i, up1, exp_up[i-1]); end
            if (i >= 2 && i <= 5) begin
                checks++; if (remain1 !== 8'(6 - i)) begin errors++; $display("FAIL free_remain c%0d: got %0d expected %0d", i, remain1, 6 - i); end
            end
        end
    endtask

    task automatic test_emergency();
        restart();
        repeat (4) @(negedge clk);
        checks++; if (remain1 !== 8'd2) begin errors++; $display("FAIL emerg_start_remain: got %0d expected 2", remain1); end
        emerg_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) en = 1'b0;
            @(negedge clk);
            checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL emerg_r k%0d: got %b expected 1", k, r1); end
            if (k >= 2) begin
                checks++; if (count1 !== 2'b10) begin errors++; $display("FAIL emerg_count k%0d: got %b expected 10", k, count1); end
            end
        end
        en = 1'b1;
        emerg_req = 1'b0;
        @(negedge clk);
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL emerg_release_r: got %b expected 0", r1); end
        @(negedge clk);
        checks++; if (remain1 !== 8'd3) begin errors++; $display("FAIL emerg_reload: got %0d expected 3", remain1); end
        repeat (2) @(negedge clk);
        checks++; if (up1 !== 1'b0) begin errors++; $display("FAIL emerg_up_early: got %b expected 0", up1); end
        @(negedge clk);
        checks++; if (up1 !== 1'b1) begin errors++; $display("FAIL emerg_up: got %b expected 1", up1); end
    endtask

    task automatic test_step_back();
        restart();
        repeat (8) @(negedge clk);
        back_req = 1'b1;
        @(negedge clk);
        back_req = 1'b0;
        checks++; if (dn1 !== 1'b1) begin errors++; $display("FAIL back_dn1: got %b expected 1", dn1); end
        @(negedge clk);
        checks++; if (count1 !== 2'b00) begin errors++; $display("FAIL back_count1: got %b expected 00", count1); end
        @(negedge clk);
        checks++; if (remain1 !== 8'd4) begin errors++; $display("FAIL back_remain1: got %0d expected 4", remain1); end
        back_req = 1'b1;
        @(negedge clk);
        back_req = 1'b0;
        checks++; if (dn1 !== 1'b1) begin errors++; $display("FAIL back_dn2: got %b expected 1", dn1); end
        @(negedge clk);
        checks++; if (count1 !== 2'b10) begin errors++; $display("FAIL back_count2: got %b expected 10", count1); end
        back_req = 1'b1;
        @(negedge clk);
        back_req = 1'b0;
        checks++; if (remain1 !== 8'd3) begin errors++; $display("FAIL back_remain2: got %0d expected 3", remain1); end
        @(negedge clk);
        checks++; if (dn1 !== 1'b0) begin errors++; $display("FAIL back_not_queued: got %b expected 0", dn1); end
        checks++; if (remain1 !== 8'd2) begin errors++; $display("FAIL back_ignored_remain: got %0d expected 2", remain1); end
    endtask

    task automatic test_prescaler();
        restart();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 4) begin checks++; if (remain2 !== 8'd2) begin errors++; $display("FAIL presc_remain4: got %0d expected 2", remain2); end end
            if (i == 5) begin checks++; if (remain2 !== 8'd1) begin errors++; $display("FAIL presc_remain5: got %0d expected 1", remain2); end end
            if (i == 7) begin checks++; if (up2 !== 1'b0) begin errors++; $display("FAIL presc_up7: got %b expected 0", up2); end end
            if (i == 8) begin checks++; if (up2 !== 1'b1) begin errors++; $display("FAIL presc_up8: got %b expected 1", up2); end end
            if (i == 9) begin checks++; if (count2 !== 2'b01) begin errors++; $display("FAIL presc_count: got %b expected 01", count2); end end
        end
    endtask

    task automatic test_disable_reset();
        restart();
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b expected 0", busy1); end
        checks++; if (remain1 !== 8'd0) begin errors++; $display("FAIL dis_remain: got %0d expected 0", remain1); end
        repeat (2) @(negedge clk);
        checks++; if (up1 !== 1'b0 || count1 !== 2'b00) begin errors++; $display("FAIL dis_hold: got up=%b count=%b expected up=0 count=00", up1, count1); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL dis_reenable_busy: got %b expected 1", busy1); end
        @(negedge clk);
        checks++; if (remain1 !== 8'd4) begin errors++; $display("FAIL dis_reload: got %0d expected 4", remain1); end
        emerg_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (r1 !== 1'b1 || count1 !== 2'b10) begin errors++; $display("FAIL clr_pre: got r=%b count=%b expected r=1 count=10", r1, count1); end
        clr = 1'b1;
        @(negedge clk);
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL clr_r: got %b expected 0", r1); end
        checks++; if (count1 !== 2'b00) begin errors++; $display("FAIL clr_count: got %b expected 00", count1); end
        clr = 1'b0; emerg_req = 1'b0;
    endtask

    task automatic test_collision();
        restart();
        repeat (5) @(negedge clk);
        checks++; if (remain1 !== 8'd1) begin errors++; $display("FAIL coll_remain: got %0d expected 1", remain1); end
        emerg_req = 1'b1; back_req = 1'b1;
        @(negedge clk);
        back_req = 1'b0;
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL coll_r: got %b expected 1", r1); end
        for (int k = 0; k < 3; k++) begin
            if (k == 1) emerg_req = 1'b0;
            checks++; if (up1 !== 1'b0 || dn1 !== 1'b0) begin errors++; $display("FAIL coll_no_pulse k%0d: got up=%b dn=%b expected 0 0", k, up1, dn1); end
            @(negedge clk);
        end
        checks++; if (count1 !== 2'b10) begin errors++; $display("FAIL coll_count: got %b expected 10", count1); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_emergency();
        test_step_back();
        test_prescaler();
        test_disable_reset();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
